// File: rtl/frame_rx_pkg.sv
// rtl/frame_rx_pkg.sv - shared constants and configuration checks for frame_receiver_p
package frame_rx_pkg;

    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic bit cfg_legal(input int data_width, input int parity_mode, input int stop_bits);
        return (data_width >= 2) && (data_width <= 32) &&
               (parity_mode >= PAR_NONE) && (parity_mode <= PAR_EVEN) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/frame_receiver_p_if.sv
// rtl/frame_receiver_p_if.sv - received-word valid/ready interface
interface frame_receiver_p_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_perr;
    logic                  m_ferr;

    modport master (output m_valid, output m_data, output m_perr, output m_ferr, input m_ready);
    modport slave  (input m_valid, input m_data, input m_perr, input m_ferr, output m_ready);
endinterface

// File: rtl/frame_receiver_p_bit_sync.sv
// rtl/frame_receiver_p_bit_sync.sv - two-flop synchroniser for the serial line
module bit_sync (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/frame_receiver_p.sv
// rtl/frame_receiver_p.sv - strobed serial frame receiver with one-entry output buffer
// RX_SYNC_EN: route the line through bit_sync before the FSM.
module frame_receiver_p
    import frame_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      bit_en,
    input  logic                      in,
    frame_receiver_p_if.master        m,
    output logic                      overrun
);
    localparam int              CW        = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    if (!cfg_legal(DATA_WIDTH, PARITY_MODE, STOP_BITS)) begin : g_bad_cfg
        $error("frame_receiver_p: illegal DATA_WIDTH/PARITY_MODE/STOP_BITS");
    end

    logic line;
`ifdef RX_SYNC_EN
    bit_sync u_sync (
        .clk  (clk),
        .arst (arst),
        .d    (in),
        .q    (line)
    );
`else
    assign line = in;
`endif

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr_acc;
    logic                  ferr_acc;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else if (bit_en) begin
            case (state)
                RX_IDLE: begin
                    if (line) begin
                        state    <= RX_DATA;
                        bit_cnt  <= '0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                RX_DATA: begin
                    shreg[bit_cnt] <= line;
                    if (bit_cnt == LAST_BIT) begin
                        state    <= (PARITY_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                        stop_cnt <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    // shreg already holds every data bit at this point
                    perr_acc <= ((^shreg) ^ line) != (PARITY_MODE == PAR_ODD);
                    state    <= RX_STOP;
                    stop_cnt <= 1'b0;
                end
                RX_STOP: begin
                    if (!line) ferr_acc <= 1'b1;
                    if (stop_cnt == LAST_STOP) state <= RX_IDLE;
                    else                       stop_cnt <= stop_cnt + 1'b1;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // The final stop sample is folded in directly so the word loads on that same edge.
    logic done;
    logic frame_ferr;
    assign done       = bit_en && (state == RX_STOP) && (stop_cnt == LAST_STOP);
    assign frame_ferr = ferr_acc | ~line;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_perr;
    logic                  out_ferr;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_ferr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done && (!out_valid || m.m_ready)) begin
                out_valid <= 1'b1;
                out_data  <= shreg;
                out_perr  <= perr_acc;
                out_ferr  <= frame_ferr;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (out_valid && m.m_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m.m_valid = out_valid;
    assign m.m_data  = out_data;
    assign m.m_perr  = out_perr;
    assign m.m_ferr  = out_ferr;

endmodule

// File: doc/frame_receiver_p.md
Name: frame_receiver_p

Overview:
Parametrised serial frame receiver, successor to the fixed 8-bit receiver FSM. Sampling is gated by an external bit-rate strobe. Supports configurable data width, parity mode and stop-bit count, and reports parity and framing errors per frame. Received words are handed downstream over a valid/ready interface through a one-entry output buffer with overrun detection. Sits between the serial line pin and the packet/host logic.

Parameters:
DATA_WIDTH, 8, data bits per frame (2..32), sent LSB first
PARITY_MODE, 1, 0 = no parity bit; 1 = odd (XOR of data and parity = 1); 2 = even (XOR = 0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  clock
arst  in  1  reset, asynchronous, active-high
bit_en  in  1  bit-rate strobe; line sampled only on cycles with bit_en=1
in  in  1  serial line; idle 0, start bit 1, stop bit(s) 1
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts word
m_data  out  DATA_WIDTH  received word
m_perr  out  1  parity error flag for m_data (0 when PARITY_MODE=0)
m_ferr  out  1  framing error flag for m_data (a stop bit sampled 0)
overrun  out  1  one-cycle pulse: completed frame dropped because the buffer was full

Behaviour:
- Reset: FSM enters IDLE. Counters, shift register and error accumulators are cleared. m_valid, m_data, m_perr, m_ferr and overrun are all 0. A partially received frame is discarded. Any word already held in the buffer is discarded.
- The FSM advances only on clk edges where bit_en=1. With bit_en=0, all state holds, except that output handshake and overrun logic run every cycle.
- FSM states:
  - IDLE: in=1 -> DATA with bit counter = 0. Otherwise stay in IDLE.
  - DATA: shift in into bit position bit_cnt, LSB first. When bit_cnt = DATA_WIDTH-1, go to PARITY (or STOP if PARITY_MODE=0). Otherwise increment bit_cnt.
  - PARITY: compute perr = (^data ^ in) != (PARITY_MODE==1). Go to STOP with stop counter = 0.
  - STOP: in=0 sets ferr. If stop_cnt = STOP_BITS-1, the frame is complete: go to IDLE. Otherwise increment stop_cnt.
- Back-to-back frames: the first bit_en sample after the final stop bit is evaluated in IDLE, so a start bit may immediately follow the stop bit.
- Framing-error frames are still delivered, with m_ferr=1. No resynchronisation beyond returning to IDLE.
- Completion latency: m_valid rises on the clk edge that samples the last stop bit, so it is visible the following cycle.
- Output buffer, one entry:
  - Load: at completion, if m_valid=0 or (m_valid and m_ready), load m_data, m_perr and m_ferr, and set m_valid=1.
  - Release: m_valid and m_ready with no simultaneous completion clears m_valid.
  - Stability: m_data, m_perr and m_ferr are held stable while m_valid=1 and m_ready=0.
- Overrun: completion while m_valid=1 and m_ready=0 drops the new frame and pulses overrun=1 for exactly one cycle. The buffer contents are unchanged.
- Widths: bit_cnt is $clog2(DATA_WIDTH) bits; stop_cnt is 1 bit. No wrap-around is possible beyond the compare values.
- m_data is not zero-masked when m_valid=0; it holds the last loaded value (0 after reset).

Optional Feature:
RX_SYNC_EN
- Defined: in passes through a 2-flop synchroniser (reset to 0) before the FSM. This adds 2 clk cycles of line latency, so the bench must hold each bit across the bit_en period.
- Undefined: in feeds the FSM directly, with no added latency.

Decomposition:
- Package frame_rx_pkg:
  - state encoding constants RX_IDLE, RX_DATA, RX_PARITY, RX_STOP;
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - parameter-legality checks (DATA_WIDTH range, STOP_BITS in {1,2}).
- One natural sub-module, bit_sync: the 2-flop synchroniser, instantiated only under RX_SYNC_EN.
- FSM, shift register and output buffer stay in the top module.

Test Plan:
- Odd parity, nominal frame. Defaults, bit_en=1 every cycle, m_ready=1. Send 1 | 1,0,1,0,0,1,0,1 | 1 | 1 (0xA5, parity 1). Expect: m_valid pulses 1 cycle, m_data=0xA5, m_perr=0, m_ferr=0.
- Parity and framing errors. Same frame with parity bit 0 -> m_data=0xA5, m_perr=1. Then a frame with stop bit 0 -> m_ferr=1, and the FSM returns to IDLE and receives a following good 0x3C correctly.
- Back-to-back with backpressure. Two frames 0x11 and 0x22 back-to-back, m_ready=0 -> first word held stable and overrun pulses once when 0x22 completes. Raise m_ready -> 0x11 accepted and m_valid drops. Repeat with m_ready asserted in the completion cycle -> 0x22 loaded, no overrun.
- Strobed sampling. bit_en=1 every 4th cycle, PARITY_MODE=2, STOP_BITS=2, DATA_WIDTH=5. Send data 0x13, parity 1, stops 1,1. Expect: m_data=0x13, no errors, m_valid one cycle after the second stop sample.
- Reset mid-frame. Assert arst after 3 data bits -> all outputs 0 immediately. After release, an idle line (in=0) produces no m_valid, and a fresh 0x5A frame is received correctly.
- Synchroniser build. With RX_SYNC_EN defined, repeat the first scenario with each bit held 4 cycles -> m_data=0xA5 and m_valid delayed by 2 cycles relative to the non-sync build.
